// File: rtl/spi_byte_master_if.sv
// Byte-stream handshake and SPI pin bundle for spi_byte_master.
// The master modport is the block itself; the slave modport is the side that feeds bytes and drives MISO.
interface spi_byte_master_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_cs_n;

   modport master (
      input  tx_valid, tx_data, tx_last, spi_miso,
      output tx_ready, rx_valid, rx_data, busy, spi_sck, spi_mosi, spi_cs_n
   );

   modport slave (
      output tx_valid, tx_data, tx_last, spi_miso,
      input  tx_ready, rx_valid, rx_data, busy, spi_sck, spi_mosi, spi_cs_n
   );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: one byte per valid/ready transfer, CS held low until a tx_last byte completes.
// SCK half-period is CLK_DIV clk cycles; every output except the reset-gated tx_ready comes straight from a flop.
module spi_byte_master #(
   parameter int CLK_DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   spi_byte_master_if.master  bus
);
   typedef enum logic [2:0] {IDLE, SHIFT, GAP, HOLD, DESEL} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [3:0] hp_q, hp_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic       last_q, last_d;
   logic       sck_q, sck_d;
   logic       cs_n_q, cs_n_d;
   logic       mosi_q, mosi_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       busy_q, busy_d;
   logic       tx_ready_q, tx_ready_d;
   logic       accept;
   logic       div_done;

   assign bus.tx_ready = tx_ready_q & ~rst;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_cs_n = cs_n_q;
   assign bus.spi_mosi = mosi_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.busy     = busy_q;

   assign accept   = bus.tx_valid & bus.tx_ready;
   assign div_done = (div_q == DIV_LAST);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      hp_d       = hp_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;

      case (state_q)
         IDLE, GAP: begin
            if (accept) begin
               state_d = SHIFT;
               tx_sh_d = bus.tx_data;
               mosi_d  = bus.tx_data[7];
               last_d  = bus.tx_last;
               div_d   = 8'd0;
               hp_d    = 4'd0;
            end
         end
         SHIFT: begin
            if (div_done) begin
               div_d = 8'd0;
               hp_d  = hp_q + 4'd1;
               if (hp_q == 4'd15) begin
                  // Eighth falling edge: byte complete, MOSI keeps its last bit.
                  rx_valid_d = 1'b1;
                  rx_data_d  = rx_sh_q;
                  state_d    = last_q ? HOLD : GAP;
               end else if (!hp_q[0]) begin
                  rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
               end else begin
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  mosi_d  = tx_sh_q[6];
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         HOLD: begin
            if (div_done) begin
               div_d   = 8'd0;
               state_d = DESEL;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         DESEL: begin
            if (div_done) begin
               div_d   = 8'd0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pin values are derived from the next state so they land in flops together with it.
      sck_d      = (state_d == SHIFT) && hp_d[0];
      cs_n_d     = (state_d == IDLE) || (state_d == DESEL);
      busy_d     = (state_d != IDLE);
      tx_ready_d = (state_d == IDLE) || (state_d == GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_q      <= 8'd0;
         hp_q       <= 4'd0;
         tx_sh_q    <= 8'd0;
         rx_sh_q    <= 8'd0;
         last_q     <= 1'b0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         tx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         hp_q       <= hp_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         last_q     <= last_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         busy_q     <= busy_d;
         tx_ready_q <= tx_ready_d;
      end
   end
endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: three instances at CLK_DIV 2, 4 and 1, checked with immediate assertions.
// Cycle index k=1 is the first cycle after the accepting clock edge.
module tb_spi_byte_master;
   logic clk;
   logic rst;
   logic miso4;
   logic [7:0] resp_pat;
   int   fall_cnt;

   int vectors = 0;
   int errors  = 0;

   int rises, rxv_cnt, rxv_at, rv1, rv2, acc_n, acc_k2, acc_k3, bad, found;
   logic prev, acc;
   logic [7:0] mbits;

   spi_byte_master_if if2();
   spi_byte_master_if if4();
   spi_byte_master_if if1();

   spi_byte_master #(.CLK_DIV(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2.master));
   spi_byte_master #(.CLK_DIV(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.master));
   spi_byte_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.master));

   assign if2.spi_miso = if2.spi_mosi;
   assign if4.spi_miso = miso4;
   assign if1.spi_miso = (fall_cnt < 8) ? resp_pat[3'(7 - fall_cnt)] : 1'b0;

   // Mode-0 responder: presents bit 7 while CS is low, advances on each SCK falling edge.
   initial fall_cnt = 0;
   always @(negedge if1.spi_sck or posedge if1.spi_cs_n) begin
      if (if1.spi_cs_n) fall_cnt <= 0;
      else              fall_cnt <= fall_cnt + 1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      miso4 = 1'b0;
      resp_pat = 8'h5A;
      if2.tx_valid = 1'b0; if2.tx_data = 8'h00; if2.tx_last = 1'b0;
      if4.tx_valid = 1'b0; if4.tx_data = 8'h00; if4.tx_last = 1'b0;
      if1.tx_valid = 1'b0; if1.tx_data = 8'h00; if1.tx_last = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_cs_n",     32'(if2.spi_cs_n), 1);
      check("rst_sck",      32'(if2.spi_sck), 0);
      check("rst_mosi",     32'(if2.spi_mosi), 0);
      check("rst_rx_valid", 32'(if2.rx_valid), 0);
      check("rst_rx_data",  32'(if2.rx_data), 0);
      check("rst_busy",     32'(if2.busy), 0);
      check("rst_tx_ready", 32'(if2.tx_ready), 0);
      check("rst_cs_n_d4",  32'(if4.spi_cs_n), 1);
      rst = 1'b0;
      tick();
      check("idle_tx_ready", 32'(if2.tx_ready), 1);
      $display("reset: done");

      // Single byte 0xA5, CLK_DIV=2, loopback
      if2.tx_data = 8'hA5; if2.tx_last = 1'b1; if2.tx_valid = 1'b1;
      tick();
      if2.tx_valid = 1'b0;
      prev = 1'b0; rises = 0; mbits = 8'h00; rxv_at = 0; rxv_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (if2.spi_sck && !prev) begin rises++; mbits = {mbits[6:0], if2.spi_mosi}; end
         prev = if2.spi_sck;
         if (if2.rx_valid) begin rxv_cnt++; rxv_at = k; end
         if (k == 1) begin
            check("sb_k1_cs_n", 32'(if2.spi_cs_n), 0);
            check("sb_k1_sck",  32'(if2.spi_sck), 0);
            check("sb_k1_mosi", 32'(if2.spi_mosi), 1);
         end
         if (k == 3)  check("sb_first_rise", 32'(if2.spi_sck), 1);
         if (k == 34) check("sb_cs_hold", 32'(if2.spi_cs_n), 0);
         if (k == 35) check("sb_cs_rise", 32'(if2.spi_cs_n), 1);
         tick();
      end
      check("sb_rises",   rises, 8);
      check("sb_mosi",    32'(mbits), 'hA5);
      check("sb_rxv_at",  rxv_at, 33);
      check("sb_rxv_cnt", rxv_cnt, 1);
      check("sb_rx_data", 32'(if2.rx_data), 'hA5);
      check("sb_idle",    32'(if2.busy), 0);
      $display("single byte A5 div2: rx=%02h rxv_at=%0d", if2.rx_data, rxv_at);

      // Two-byte frame 0x3C,0xFF then backpressured 0x81, CLK_DIV=4, MISO=0
      if4.tx_data = 8'h3C; if4.tx_last = 1'b0; if4.tx_valid = 1'b1;
      check("tb_ready", 32'(if4.tx_ready), 1);
      tick();
      if4.tx_data = 8'hFF; if4.tx_last = 1'b1;
      rxv_cnt = 0; rv1 = 0; rv2 = 0; acc_n = 0; acc_k2 = 0; acc_k3 = 0; bad = 0;
      for (int k = 1; k <= 150; k++) begin
         if (if4.rx_valid) begin
            rxv_cnt++;
            if (rxv_cnt == 1) rv1 = k; else rv2 = k;
            check("tb_rx_data", 32'(if4.rx_data), 0);
         end
         if (k <= 133 && if4.spi_cs_n) bad++;
         if (k == 10)  check("tb_ready_shift", 32'(if4.tx_ready), 0);
         if (k == 131) check("tb_ready_hold",  32'(if4.tx_ready), 0);
         if (k == 134) check("tb_cs_rise",     32'(if4.spi_cs_n), 1);
         if (k == 135) check("tb_ready_desel", 32'(if4.tx_ready), 0);
         acc = if4.tx_valid && if4.tx_ready;
         if (acc) begin
            acc_n++;
            if (acc_n == 1) acc_k2 = k; else acc_k3 = k;
         end
         tick();
         if (acc && acc_n == 1) if4.tx_data = 8'h81;
         if (acc && acc_n == 2) if4.tx_valid = 1'b0;
      end
      check("tb_cs_low",  bad, 0);
      check("tb_rxv_cnt", rxv_cnt, 2);
      check("tb_rv1",     rv1, 65);
      check("tb_spacing", rv2 - rv1, 65);
      check("tb_acc2_k",  acc_k2, 65);
      check("tb_acc3_k",  acc_k3, 138);
      check("tb_acc_n",   acc_n, 2);
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         if (!if4.busy) found = 1; else tick();
      end
      check("tb_idle_timeout", found, 1);
      $display("two-byte 3C/FF div4: rv1=%0d rv2=%0d acc2=%0d acc3=%0d", rv1, rv2, acc_k2, acc_k3);

      // Stall in GAP: 0x96 with MISO=1, 100-cycle gap, then 0x69 with MISO=0
      miso4 = 1'b1;
      if4.tx_data = 8'h96; if4.tx_last = 1'b0; if4.tx_valid = 1'b1;
      tick();
      if4.tx_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (if4.rx_valid) found = 1; else tick();
      end
      check("st_rxv_timeout", found, 1);
      check("st_rx_data", 32'(if4.rx_data), 'hFF);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (if4.spi_cs_n !== 1'b0 || if4.spi_sck !== 1'b0 || if4.tx_ready !== 1'b1) bad++;
         tick();
      end
      check("st_gap_pins", bad, 0);
      miso4 = 1'b0;
      if4.tx_data = 8'h69; if4.tx_last = 1'b1; if4.tx_valid = 1'b1;
      tick();
      if4.tx_valid = 1'b0;
      prev = 1'b0; rises = 0; mbits = 8'h00; rxv_at = 0;
      for (int k = 1; k <= 80; k++) begin
         if (if4.spi_sck && !prev) begin rises++; mbits = {mbits[6:0], if4.spi_mosi}; end
         prev = if4.spi_sck;
         if (if4.rx_valid) rxv_at = k;
         tick();
      end
      check("st_rises",   rises, 8);
      check("st_mosi",    32'(mbits), 'h69);
      check("st_rxv_at",  rxv_at, 65);
      check("st_rx_data2", 32'(if4.rx_data), 0);
      $display("stall div4: resumed mosi=%02h rx=%02h", mbits, if4.rx_data);

      // Reset mid-byte, CLK_DIV=2: 0xF0, reset after third SCK pulse
      if2.tx_data = 8'hF0; if2.tx_last = 1'b1; if2.tx_valid = 1'b1;
      tick();
      if2.tx_valid = 1'b0;
      prev = 1'b0; rises = 0;
      for (int k = 1; k <= 12; k++) begin
         if (if2.spi_sck && !prev) rises++;
         prev = if2.spi_sck;
         tick();
      end
      check("rm_rises",  rises, 3);
      check("rm_mosi_pre", 32'(if2.spi_mosi), 1);
      rst = 1'b1;
      tick();
      check("rm_cs_n",     32'(if2.spi_cs_n), 1);
      check("rm_sck",      32'(if2.spi_sck), 0);
      check("rm_mosi",     32'(if2.spi_mosi), 0);
      check("rm_tx_ready", 32'(if2.tx_ready), 0);
      check("rm_busy",     32'(if2.busy), 0);
      rst = 1'b0;
      rxv_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (if2.rx_valid) rxv_cnt++;
         tick();
      end
      check("rm_no_rxv", rxv_cnt, 0);
      if2.tx_data = 8'hC3; if2.tx_last = 1'b1; if2.tx_valid = 1'b1;
      tick();
      if2.tx_valid = 1'b0;
      prev = 1'b0; rises = 0; mbits = 8'h00; rxv_at = 0;
      for (int k = 1; k <= 40; k++) begin
         if (if2.spi_sck && !prev) begin rises++; mbits = {mbits[6:0], if2.spi_mosi}; end
         prev = if2.spi_sck;
         if (if2.rx_valid) rxv_at = k;
         tick();
      end
      check("rm_fresh_mosi", 32'(mbits), 'hC3);
      check("rm_fresh_rx",   32'(if2.rx_data), 'hC3);
      check("rm_fresh_at",   rxv_at, 33);
      $display("reset mid-byte div2: fresh rx=%02h", if2.rx_data);

      // Independent responder, CLK_DIV=1, pattern 0x5A
      if1.tx_data = 8'h00; if1.tx_last = 1'b1; if1.tx_valid = 1'b1;
      check("r1_ready", 32'(if1.tx_ready), 1);
      tick();
      if1.tx_valid = 1'b0;
      prev = 1'b0; rises = 0; mbits = 8'hFF; rxv_at = 0;
      for (int k = 1; k <= 25; k++) begin
         if (if1.spi_sck && !prev) begin rises++; mbits = {mbits[6:0], if1.spi_mosi}; end
         prev = if1.spi_sck;
         if (if1.rx_valid) rxv_at = k;
         if (k == 2) check("r1_first_rise", 32'(if1.spi_sck), 1);
         tick();
      end
      check("r1_rises",   rises, 8);
      check("r1_mosi",    32'(mbits), 0);
      check("r1_rxv_at",  rxv_at, 17);
      check("r1_rx_data", 32'(if1.rx_data), 'h5A);
      $display("responder div1: rx=%02h rxv_at=%0d", if1.rx_data, rxv_at);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
